// File: rtl/cmd_sender_pkg.sv
// cmd_sender_pkg
// Shared definitions for the command sender: playback FSM states, error
// codes reported on error_code, and the line terminator characters.
package cmd_sender_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdNum,
        StWaitNum,
        StRdByte,
        StWaitByte,
        StSend,
        StSendCr,
        StSendLf,
        StGap,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrCountOvf = 2'd1,
        ErrNoTerm   = 2'd2
    } err_e;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/cmd_gap_timer.sv
// cmd_gap_timer
// Loadable down-counter that stops at zero; used to time the idle gap
// between commands.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value this cycle (wins over counting)
//   load_value  - value to load
//   zero        - counter currently at zero
module cmd_gap_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cmd_sender.sv
// cmd_sender
// Plays back a table of line-oriented commands from a byte-wide memory into
// a UART TX FIFO. Address 0 holds the command count; byte j of command i
// lives at i*CMD_WIDTH+j+1. Each command ends with CR LF on the wire: a CR
// byte is sent and followed by LF, a 0x00 byte is replaced by CR LF, and a
// command with no terminator in CMD_WIDTH bytes gets CR LF plus an error.
// Optional feature: define CMD_SENDER_GAP_EN to make the inter-command gap
// last GAP_CYCLES clocks (0 means 1); otherwise the gap is a single clock.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   enable             - playback permitted; low aborts to idle
//   start              - pulse that starts playback (ignored while busy)
//   mem_rd_en/addr     - memory read strobe and byte address
//   mem_rd_data        - read data, valid the cycle after mem_rd_en
//   tx_data/valid      - byte offered to the TX FIFO
//   tx_ready           - TX FIFO can accept
//   busy               - playback in progress
//   cmd_idx            - index of the command being sent
//   done               - one-cycle pulse at end of playback
//   error_pulse/code   - one-cycle error flag and its cause
module cmd_sender
    import cmd_sender_pkg::*;
#(
    parameter int unsigned CMD_WIDTH  = 32,
    parameter int unsigned CMD_DEPTH  = 16,
    parameter int unsigned GAP_CYCLES = 1000,
    localparam int unsigned AW = $clog2(CMD_DEPTH * CMD_WIDTH + 1),
    localparam int unsigned IW = $clog2(CMD_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic [IW-1:0] cmd_idx,
    output logic          done,
    output logic          error_pulse,
    output logic [1:0]    error_code
);

    localparam int unsigned JW = $clog2(CMD_WIDTH + 1);
    localparam int unsigned NW = $clog2(CMD_DEPTH + 1);

`ifdef CMD_SENDER_GAP_EN
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The first GAP cycle is spent with the loaded value, hence the -1.
    localparam logic [GW-1:0] GapLoad = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
`else
    localparam int unsigned GW = 1;
    localparam logic [GW-1:0] GapLoad = '0;
`endif

    state_e          state_q, state_d;
    logic [NW-1:0]   num_q;
    logic [IW-1:0]   cmd_idx_q;
    logic [JW-1:0]   j_q;
    logic [7:0]      byte_q;
    logic            err_pulse_q;
    err_e            err_code_q;

    logic            err_set;
    err_e            err_code_set;
    logic            last_cmd;
    logic            count_ovf;
    logic            gap_load;
    logic            gap_zero;
    logic [AW-1:0]   byte_addr;

    assign last_cmd  = ((NW'(cmd_idx_q) + NW'(1)) == num_q);
    assign count_ovf = (32'(mem_rd_data) > CMD_DEPTH);
    assign byte_addr = AW'(cmd_idx_q) * AW'(CMD_WIDTH) + AW'(j_q) + AW'(1);
    assign gap_load  = (state_q == StSendLf) && tx_ready && !last_cmd;

    cmd_gap_timer #(
        .WIDTH (GW)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (GapLoad),
        .zero       (gap_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        err_set      = 1'b0;
        err_code_set = ErrNone;
        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    state_d = StRdNum;
                end
            end
            StRdNum:   state_d = StWaitNum;
            StWaitNum: begin
                if (mem_rd_data == 8'h00) begin
                    state_d = StFinish;
                end else begin
                    state_d = StRdByte;
                    if (count_ovf) begin
                        err_set      = 1'b1;
                        err_code_set = ErrCountOvf;
                    end
                end
            end
            StRdByte:   state_d = StWaitByte;
            // A 0x00 byte is never offered; it is replaced by CR LF.
            StWaitByte: state_d = (mem_rd_data == 8'h00) ? StSendCr : StSend;
            StSend: begin
                if (tx_ready) begin
                    if (byte_q == CR) begin
                        state_d = StSendLf;
                    end else if (j_q == JW'(CMD_WIDTH - 1)) begin
                        state_d      = StSendCr;
                        err_set      = 1'b1;
                        err_code_set = ErrNoTerm;
                    end else begin
                        state_d = StRdByte;
                    end
                end
            end
            StSendCr: begin
                if (tx_ready) begin
                    state_d = StSendLf;
                end
            end
            StSendLf: begin
                if (tx_ready) begin
                    state_d = last_cmd ? StFinish : StGap;
                end
            end
            StGap: begin
                if (gap_zero) begin
                    state_d = StRdByte;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort: the only path that withdraws tx_valid without a transfer.
        if ((state_q != StIdle) && !enable) begin
            state_d = StIdle;
            err_set = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q       <= '0;
            cmd_idx_q   <= '0;
            j_q         <= '0;
            byte_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ErrNone;
        end else begin
            err_pulse_q <= err_set;
            err_code_q  <= err_set ? err_code_set : ErrNone;
            if (state_q == StWaitNum) begin
                num_q     <= count_ovf ? NW'(CMD_DEPTH) : NW'(mem_rd_data);
                cmd_idx_q <= '0;
                j_q       <= '0;
            end
            if (state_q == StWaitByte) begin
                byte_q <= mem_rd_data;
            end
            // j stops at CMD_WIDTH: the last non-terminator transfer exits to CR.
            if ((state_q == StSend) && tx_ready && (byte_q != CR)) begin
                j_q <= j_q + JW'(1);
            end
            if ((state_q == StSendLf) && tx_ready) begin
                j_q <= '0;
                if (!last_cmd) begin
                    cmd_idx_q <= cmd_idx_q + IW'(1);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        done      = 1'b0;
        unique case (state_q)
            StRdNum: mem_rd_en = 1'b1;
            StRdByte: begin
                mem_rd_en = 1'b1;
                mem_addr  = byte_addr;
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = byte_q;
            end
            StSendCr: begin
                tx_valid = 1'b1;
                tx_data  = CR;
            end
            StSendLf: begin
                tx_valid = 1'b1;
                tx_data  = LF;
            end
            StFinish: done = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign cmd_idx     = cmd_idx_q;
    assign error_pulse = err_pulse_q;
    assign error_code  = err_code_q;

endmodule

// File: tb/tb_cmd_sender.sv
// tb_cmd_sender
// Directed bench for cmd_sender: a behavioural byte memory with one-cycle
// read latency, a monitor that logs TX transfers and pulses, and one task
// per scenario with hand-computed expected streams.
module tb_cmd_sender;

    localparam int unsigned CMD_WIDTH  = 32;
    localparam int unsigned CMD_DEPTH  = 16;
    localparam int unsigned GAP_CYCLES = 10;
    localparam int unsigned AW = $clog2(CMD_DEPTH * CMD_WIDTH + 1);
    localparam int unsigned IW = $clog2(CMD_DEPTH);
    localparam int MEM_SIZE = CMD_DEPTH * CMD_WIDTH + 1;
`ifdef CMD_SENDER_GAP_EN
    localparam int EXP_GAP = 10;
`else
    localparam int EXP_GAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = 8'h00;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic [IW-1:0] cmd_idx;
    logic          done;
    logic          error_pulse;
    logic [1:0]    error_code;

    cmd_sender #(
        .CMD_WIDTH  (CMD_WIDTH),
        .CMD_DEPTH  (CMD_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .cmd_idx     (cmd_idx),
        .done        (done),
        .error_pulse (error_pulse),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:MEM_SIZE-1];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Monitor
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] txq[$];
    int         idxq[$];
    int         lf_cyc[$];
    int         rd_cyc[$];
    logic [7:0] exp_q[$];
    int         done_cnt, err1_cnt, err2_cnt, errx_cnt;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                txq.push_back(tx_data);
                idxq.push_back(int'(cmd_idx));
                if (tx_data == 8'h0A) lf_cyc.push_back(cyc);
            end
            if (mem_rd_en) rd_cyc.push_back(cyc);
            if (done) done_cnt++;
            if (error_pulse) begin
                if (error_code == 2'd1) err1_cnt++;
                else if (error_code == 2'd2) err2_cnt++;
                else errx_cnt++;
            end
        end
    end

    task automatic clear_log();
        txq.delete(); idxq.delete(); lf_cyc.delete(); rd_cyc.delete(); exp_q.delete();
        done_cnt = 0; err1_cnt = 0; err2_cnt = 0; errx_cnt = 0;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < MEM_SIZE; k++) mem[k] = 8'h55;
    endtask

    // term < 0 means no terminator byte is written
    task automatic put_cmd(input int i, input string s, input int term);
        for (int k = 0; k < s.len(); k++) mem[i * CMD_WIDTH + k + 1] = s[k];
        if (term >= 0) mem[i * CMD_WIDTH + s.len() + 1] = 8'(term);
    endtask

    function automatic void push_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base;
        base = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; enable = 1'b1; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        checks++; if (cmd_idx !== '0) begin errors++; $display("FAIL reset_cmd_idx: got %0d want 0", cmd_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error_pulse !== 1'b0 || error_code !== 2'd0) begin
            errors++; $display("FAIL reset_error: got %b/%0d want 0/0", error_pulse, error_code);
        end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_cmds();
        clear_mem(); clear_log(); mem[0] = 8'd0;
        pulse_start();
        checks++; if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== '0) begin
            errors++; $display("FAIL zero_rd_num: got busy=%b rd=%b addr=%0h want 1 1 0", busy, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL zero_wait_num: got busy=%b done=%b want 1 0", busy, done);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL zero_done: got busy=%b done=%b want 1 1", busy, done);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL zero_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        checks++; if (txq.size() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_tx: got bytes=%0d dones=%0d want 0 1", txq.size(), done_cnt);
        end
    endtask

    task automatic test_two_cmds();
        bit ok;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd2; put_cmd(0, "AT", 8'h0D); put_cmd(1, "AT+X", 8'h0D);
        push_str("AT"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        push_str("AT+X"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        pulse_start();
        @(negedge clk); @(negedge clk);
        checks++; if (mem_rd_en !== 1'b1 || mem_addr !== AW'(1)) begin
            errors++; $display("FAIL two_first_read: got rd=%b addr=%0d want 1 1", mem_rd_en, mem_addr);
        end
        @(negedge clk); @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            errors++; $display("FAIL two_latency: got valid=%b data=%0h want 1 41", tx_valid, tx_data);
        end
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_timeout: got no done want done"); end
        checks++; if (txq.size() != exp_q.size()) begin
            errors++; $display("FAIL two_len: got %0d want %0d", txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_q[i]) begin
                errors++; $display("FAIL two_byte%0d: got %0h want %0h", i, txq[i], exp_q[i]);
            end
            checks++; if (idxq[i] != ((i < 4) ? 0 : 1)) begin
                errors++; $display("FAIL two_idx%0d: got %0d want %0d", i, idxq[i], (i < 4) ? 0 : 1);
            end
        end
        @(negedge clk);
        checks++; if (done_cnt != 1 || err1_cnt + err2_cnt + errx_cnt != 0) begin
            errors++; $display("FAIL two_pulses: got dones=%0d errs=%0d want 1 0", done_cnt, err1_cnt + err2_cnt + errx_cnt);
        end
    endtask

    task automatic test_null_term();
        bit ok;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd1; put_cmd(0, "AB", 8'h00);
        push_str("AB"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        pulse_start();
        wait_done(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL null_timeout: got no done want done"); end
        checks++; if (txq.size() != exp_q.size()) begin
            errors++; $display("FAIL null_len: got %0d want %0d", txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_q[i]) begin
                errors++; $display("FAIL null_byte%0d: got %0h want %0h", i, txq[i], exp_q[i]);
            end
        end
        checks++; if (err1_cnt + err2_cnt + errx_cnt != 0) begin
            errors++; $display("FAIL null_error: got %0d pulses want 0", err1_cnt + err2_cnt + errx_cnt);
        end
    endtask

    task automatic test_no_term();
        bit ok;
        string zs;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        zs = "";
        for (int k = 0; k < CMD_WIDTH; k++) zs = {zs, "Z"};
        mem[0] = 8'd1; put_cmd(0, zs, -1);
        push_str(zs); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        pulse_start();
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL noterm_timeout: got no done want done"); end
        checks++; if (txq.size() != exp_q.size()) begin
            errors++; $display("FAIL noterm_len: got %0d want %0d", txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_q[i]) begin
                errors++; $display("FAIL noterm_byte%0d: got %0h want %0h", i, txq[i], exp_q[i]);
            end
        end
        checks++; if (err2_cnt != 1 || err1_cnt != 0 || errx_cnt != 0) begin
            errors++; $display("FAIL noterm_error: got code2=%0d code1=%0d other=%0d want 1 0 0", err2_cnt, err1_cnt, errx_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd20;
        for (int i = 0; i < CMD_DEPTH; i++) begin
            put_cmd(i, "", -1);
            mem[i * CMD_WIDTH + 1] = 8'h61 + 8'(i);
            mem[i * CMD_WIDTH + 2] = 8'h0D;
            exp_q.push_back(8'h61 + 8'(i)); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        end
        pulse_start();
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got no done want done"); end
        checks++; if (txq.size() != exp_q.size()) begin
            errors++; $display("FAIL ovf_len: got %0d want %0d", txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovf_byte%0d: got %0h want %0h", i, txq[i], exp_q[i]);
            end
        end
        checks++; if (lf_cyc.size() != 16) begin
            errors++; $display("FAIL ovf_cmds: got %0d want 16", lf_cyc.size());
        end
        checks++; if (idxq.size() == 0 || idxq[idxq.size() - 1] != 15) begin
            errors++; $display("FAIL ovf_last_idx: got %0d want 15", (idxq.size() == 0) ? -1 : idxq[idxq.size() - 1]);
        end
        checks++; if (err1_cnt != 1 || err2_cnt != 0) begin
            errors++; $display("FAIL ovf_error: got code1=%0d code2=%0d want 1 0", err1_cnt, err2_cnt);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd1; put_cmd(0, "HELLO", 8'h0D);
        push_str("HELLO"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txq.size() >= 2) begin ok = 1'b1; break; end
        end
        tx_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_two_bytes: got %0d want 2", txq.size()); end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok || tx_data !== 8'h4C) begin
            errors++; $display("FAIL stall_offer: got valid=%b data=%0h want 1 4c", tx_valid, tx_data);
        end
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            @(negedge clk);
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4C) begin
                errors++; $display("FAIL stall_hold%0d: got valid=%b data=%0h want 1 4c", i, tx_valid, tx_data);
            end
        end
        start = 1'b0;
        tx_ready = 1'b1;
        wait_done(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done want done"); end
        checks++; if (txq.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_len: got %0d want %0d", txq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
            checks++; if (txq[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_byte%0d: got %0h want %0h", i, txq[i], exp_q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_restart: got dones=%0d busy=%b want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd2; put_cmd(0, "ABCDEFGH", 8'h0D); put_cmd(1, "XY", 8'h0D);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txq.size() >= 3) begin ok = 1'b1; break; end
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 10 && tx_valid !== 1'b1; i++) @(negedge clk);
        checks++; if (!ok || tx_valid !== 1'b1 || tx_data !== 8'h44) begin
            errors++; $display("FAIL abort_offer: got valid=%b data=%0h want 1 44", tx_valid, tx_data);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got valid=%b busy=%b want 0 0", tx_valid, busy);
        end
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != 0 || txq.size() != 3) begin
            errors++; $display("FAIL abort_no_done: got dones=%0d bytes=%0d want 0 3", done_cnt, txq.size());
        end
        enable = 1'b1;
    endtask

    task automatic test_gap();
        bit ok;
        int rd_after;
        clear_mem(); clear_log(); tx_ready = 1'b1;
        mem[0] = 8'd2; put_cmd(0, "A", 8'h0D); put_cmd(1, "B", 8'h0D);
        pulse_start();
        wait_done(500, ok);
        checks++; if (!ok || lf_cyc.size() != 2) begin
            errors++; $display("FAIL gap_run: got done=%b lfs=%0d want 1 2", ok, lf_cyc.size());
        end
        rd_after = -1;
        if (lf_cyc.size() > 0) begin
            foreach (rd_cyc[i]) begin
                if (rd_after < 0 && rd_cyc[i] > lf_cyc[0]) rd_after = rd_cyc[i];
            end
        end
        checks++; if (rd_after < 0 || rd_after - lf_cyc[0] - 1 != EXP_GAP) begin
            errors++; $display("FAIL gap_len: got %0d want %0d", (rd_after < 0) ? -1 : rd_after - lf_cyc[0] - 1, EXP_GAP);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; start = 1'b0; tx_ready = 1'b0;
        clear_mem(); clear_log();
        test_reset();
        test_zero_cmds();
        test_two_cmds();
        test_null_term();
        test_no_term();
        test_overflow();
        test_stall();
        test_abort();
        test_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
